// File: rtl/sram_arbiter_if.sv
// Signal bundle between the requesters, the arbiter and the single-port SRAM.
// The req_lock vector is present only when SRAM_ARB_LOCK_EN is defined.
interface sram_arbiter_if #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 8
) ();
    logic [NREQ-1:0]    req;
    logic [NREQ-1:0]    req_we;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
`ifdef SRAM_ARB_LOCK_EN
    logic [NREQ-1:0]    req_lock;
`endif
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rvalid;
    logic [DW-1:0]      rdata;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

`ifdef SRAM_ARB_LOCK_EN
    modport slave (
        input  req, req_we, req_addr, req_wdata, req_lock, mem_rdata,
        output gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output req, req_we, req_addr, req_wdata, req_lock, mem_rdata,
        input  gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
    );
`else
    modport slave (
        input  req, req_we, req_addr, req_wdata, mem_rdata,
        output gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output req, req_we, req_addr, req_wdata, mem_rdata,
        input  gnt, rvalid, rdata, mem_we, mem_addr, mem_wdata
    );
`endif
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among NREQ requesters.
// Define SRAM_ARB_LOCK_EN to add per-requester bus locking (req_lock).
module sram_arbiter #(
    parameter int NREQ = 2,
    parameter int AW   = 4,
    parameter int DW   = 8
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);
    localparam int            IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NREQ - 1);

    logic [IW-1:0]   r_last_gnt;
    logic [NREQ-1:0] r_rvalid;
    logic            w_win_found;
    logic [IW-1:0]   w_win_idx;
    logic [IW-1:0]   w_cand;
    logic            w_hit;
    logic            w_gnt_any;
    logic [IW-1:0]   w_gnt_idx;
    logic [NREQ-1:0] w_gnt;
    logic [AW-1:0]   w_addr_arr  [NREQ];
    logic [DW-1:0]   w_wdata_arr [NREQ];

    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int step);
        int sum;
        sum = (int'(base) + step) % NREQ;
        return IW'(sum);
    endfunction

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign w_addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
        assign w_wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
    end

    // Round-robin search: first asserted request after the last winner.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        w_hit       = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_cand      = rr_index(r_last_gnt, k);
            w_hit       = !w_win_found && bus.req[w_cand];
            w_win_idx   = w_hit ? w_cand : w_win_idx;
            w_win_found = w_win_found | w_hit;
        end
    end

`ifdef SRAM_ARB_LOCK_EN
    typedef enum logic [0:0] {
        ST_UNLOCKED = 1'b0,
        ST_LOCKED   = 1'b1
    } lock_state_t;

    lock_state_t   r_lock_state;
    lock_state_t   w_lock_state_nxt;
    logic [IW-1:0] r_lock_owner;
    logic [IW-1:0] w_lock_owner_nxt;

    // Lock state and owner registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lock_state <= ST_UNLOCKED;
            r_lock_owner <= '0;
        end else begin
            r_lock_state <= w_lock_state_nxt;
            r_lock_owner <= w_lock_owner_nxt;
        end
    end

    // While locked only the owner may win; any unlocked grant or dropped req releases it.
    always_comb begin
        w_lock_state_nxt = r_lock_state;
        w_lock_owner_nxt = r_lock_owner;
        w_gnt_any        = 1'b0;
        w_gnt_idx        = w_win_idx;
        case (r_lock_state)
            ST_UNLOCKED: begin
                w_gnt_any = w_win_found && !rst;
                if (w_gnt_any && bus.req_lock[w_win_idx]) begin
                    w_lock_state_nxt = ST_LOCKED;
                    w_lock_owner_nxt = w_win_idx;
                end else begin
                    w_lock_state_nxt = ST_UNLOCKED;
                end
            end
            ST_LOCKED: begin
                w_gnt_idx = r_lock_owner;
                w_gnt_any = bus.req[r_lock_owner] && !rst;
                if (!bus.req[r_lock_owner] || !bus.req_lock[r_lock_owner]) begin
                    w_lock_state_nxt = ST_UNLOCKED;
                end else begin
                    w_lock_state_nxt = ST_LOCKED;
                end
            end
            default: begin
                w_lock_state_nxt = ST_UNLOCKED;
                w_lock_owner_nxt = '0;
            end
        endcase
    end
`else
    // Grant selection without locking.
    always_comb begin
        w_gnt_any = w_win_found && !rst;
        w_gnt_idx = w_win_idx;
    end
`endif

    // One-hot grant vector.
    always_comb begin
        w_gnt = '0;
        if (w_gnt_any) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end else begin
            w_gnt = '0;
        end
    end

    // The SRAM port is all-zero when idle so no spurious write can occur.
    assign bus.gnt       = w_gnt;
    assign bus.mem_we    = w_gnt_any & bus.req_we[w_gnt_idx];
    assign bus.mem_addr  = w_gnt_any ? w_addr_arr[w_gnt_idx]  : '0;
    assign bus.mem_wdata = w_gnt_any ? w_wdata_arr[w_gnt_idx] : '0;
    assign bus.rvalid    = r_rvalid;
    assign bus.rdata     = bus.mem_rdata;

    // Round-robin pointer; reset value gives requester 0 first priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_gnt <= LAST_IDX;
        end else if (w_gnt_any) begin
            r_last_gnt <= w_gnt_idx;
        end else begin
            r_last_gnt <= r_last_gnt;
        end
    end

    // Read ownership tracks the SRAM's one-cycle registered read.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_gnt & ~bus.req_we;
        end
    end
endmodule
